// File: rtl/layer_ser_pkg.sv
// Shared types and helpers for the layer serializer: stream FSM states and index width.
package layer_ser_pkg;

  typedef enum logic {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_t;

  function automatic int idx_w(input int nn);
    return $clog2(nn);
  endfunction

endpackage

// File: rtl/seq_argmax.sv
// Running signed-max tracker over a serial word stream; reports the winning index
// the cycle after the last word. Strict compare keeps the lowest index on ties.
module seq_argmax #(
  parameter int IW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          valid,
  input  logic [DW-1:0] data,
  input  logic          last,
  input  logic [IW-1:0] index,
  output logic [IW-1:0] max_idx,
  output logic          max_valid
);

  logic signed [DW-1:0] run_max;
  logic [IW-1:0]        run_idx;
  logic                 take;

  // Index 0 restarts the tracker so no explicit clear between vectors is needed.
  assign take = valid && ((index == '0) || ($signed(data) > run_max));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_max   <= '0;
      run_idx   <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= valid && last;
      if (take) begin
        run_max <= $signed(data);
        run_idx <= index;
      end
      if (valid && last) max_idx <= take ? index : run_idx;
    end
  end

endmodule

// File: rtl/layer_serializer.sv
// Collects per-neuron layer results and streams them one word per cycle in neuron order.
// Optional argmax tracker enabled by defining LAYER_SER_ARGMAX_EN.
module layer_serializer
  import layer_ser_pkg::*;
#(
  parameter int NN        = 10,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    o_last,
  output logic                    busy,
  output logic                    overflow
`ifdef LAYER_SER_ARGMAX_EN
  ,
  output logic [idx_w(NN)-1:0]    max_idx,
  output logic                    max_valid
`endif
);

  localparam int            IW       = idx_w(NN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  ser_state_t           state, state_next;
  logic [IW-1:0]        cnt, cnt_next;
  logic [NN-1:0]        mask, mask_next, cap_we, clash;
  logic [dataWidth-1:0] cap     [NN];
  logic [dataWidth-1:0] buf_mem [NN];
  logic                 at_end, transfer;
  logic                 o_valid_next, o_last_next, busy_next, overflow_next;
  logic [dataWidth-1:0] o_data_next;

  assign at_end   = (state == SER_STREAM) && (cnt == LAST_IDX);
  assign transfer = (&mask) && ((state == SER_IDLE) || at_end);

  // On a transfer the mask restarts from this cycle's arrivals, which belong to the next vector.
  genvar gi;
  generate
    for (gi = 0; gi < NN; gi++) begin : g_collect
      assign cap_we[gi]    = i_valid[gi] & (transfer | ~mask[gi]);
      assign mask_next[gi] = transfer ? i_valid[gi] : (mask[gi] | i_valid[gi]);
      assign clash[gi]     = i_valid[gi] & mask[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NN; i++) begin
      if (cap_we[i]) cap[i] <= i_data[i*dataWidth +: dataWidth];
      if (transfer)  buf_mem[i] <= cap[i];
    end
  end

  // o_data is registered, so the first word comes straight from cap while buf_mem loads.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    o_valid_next = 1'b0;
    o_last_next  = 1'b0;
    o_data_next  = '0;
    case (state)
      SER_IDLE, SER_STREAM: begin
        if (transfer) begin
          state_next   = SER_STREAM;
          cnt_next     = '0;
          o_valid_next = 1'b1;
          o_data_next  = cap[0];
        end else if ((state == SER_STREAM) && !at_end) begin
          cnt_next     = cnt + 1'b1;
          o_valid_next = 1'b1;
          o_data_next  = buf_mem[cnt_next];
          o_last_next  = (cnt_next == LAST_IDX);
        end else begin
          state_next = SER_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = SER_IDLE;
        cnt_next   = '0;
      end
    endcase
    busy_next     = (|mask_next) || (state_next == SER_STREAM);
    overflow_next = overflow || ((|clash) && !transfer);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= SER_IDLE;
      cnt      <= '0;
      mask     <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      mask     <= mask_next;
      o_valid  <= o_valid_next;
      o_data   <= o_data_next;
      o_last   <= o_last_next;
      busy     <= busy_next;
      overflow <= overflow_next;
    end
  end

`ifdef LAYER_SER_ARGMAX_EN
  seq_argmax #(
    .IW (IW),
    .DW (dataWidth)
  ) u_argmax (
    .clk       (clk),
    .rstn      (rstn),
    .valid     (o_valid),
    .data      (o_data),
    .last      (o_last),
    .index     (cnt),
    .max_idx   (max_idx),
    .max_valid (max_valid)
  );
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer: basic, staggered, back-to-back, overflow,
// mid-stream reset and (with LAYER_SER_ARGMAX_EN) argmax vectors.
module tb_layer_serializer;

  localparam int NN = 10;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NN-1:0]    i_valid;
  logic [NN*DW-1:0] i_data;
  logic             o_valid;
  logic [DW-1:0]    o_data;
  logic             o_last;
  logic             busy;
  logic             overflow;
`ifdef LAYER_SER_ARGMAX_EN
  logic [3:0]       max_idx;
  logic             max_valid;
`endif

  int tests  = 0;
  int failed = 0;

  layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_last   (o_last),
    .busy     (busy),
    .overflow (overflow)
`ifdef LAYER_SER_ARGMAX_EN
    ,
    .max_idx  (max_idx),
    .max_valid(max_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] v);
    i_data[i*DW +: DW] = v;
  endtask

  // Checks a full 10-word stream whose first word is visible now, then the idle beat after it.
  task automatic expect_stream(input string tag, input int base);
    for (int k = 0; k < NN; k++) begin
      check($sformatf("%s_valid%0d", tag, k), {31'd0, o_valid}, 32'd1);
      check($sformatf("%s_data%0d", tag, k), {16'd0, o_data}, {16'd0, 16'(base + k)});
      check($sformatf("%s_last%0d", tag, k), {31'd0, o_last}, {31'd0, (k == NN - 1)});
      tick();
    end
    check($sformatf("%s_end_valid", tag), {31'd0, o_valid}, 32'd0);
  endtask

  initial begin
    rstn    = 1'b0;
    i_valid = '0;
    i_data  = '0;
    tick();
    tick();
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data", {16'd0, o_data}, 32'd0);
    check("rst_last", {31'd0, o_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
`ifdef LAYER_SER_ARGMAX_EN
    check("rst_maxidx", {28'd0, max_idx}, 32'd0);
    check("rst_maxvalid", {31'd0, max_valid}, 32'd0);
`endif
    rstn = 1'b1;
    tick();

    // Basic: all valid in cycle T, words 1..10 in T+2..T+11.
    for (int i = 0; i < NN; i++) set_word(i, 16'(i + 1));
    i_valid = '1;
    tick();
    i_valid = '0;
    check("basic_t1_valid", {31'd0, o_valid}, 32'd0);
    check("basic_t1_busy", {31'd0, busy}, 32'd1);
    tick();
    expect_stream("basic", 1);
    check("basic_busy_after", {31'd0, busy}, 32'd0);

    // Staggered arrival from neuron 9 down to 0.
    for (int j = NN - 1; j >= 1; j--) begin
      i_valid = '0;
      i_valid[j] = 1'b1;
      set_word(j, 16'(100 + j));
      tick();
      check($sformatf("stag_wait%0d", j), {31'd0, o_valid}, 32'd0);
    end
    i_valid = '0;
    i_valid[0] = 1'b1;
    set_word(0, 16'd100);
    tick();
    i_valid = '0;
    check("stag_t1_valid", {31'd0, o_valid}, 32'd0);
    tick();
    expect_stream("stag", 100);

    // Back-to-back: second vector arrives at beat 3 of the first stream.
    for (int i = 0; i < NN; i++) set_word(i, 16'(200 + i));
    i_valid = '1;
    tick();
    i_valid = '0;
    tick();
    for (int b = 0; b < 2 * NN; b++) begin
      check($sformatf("b2b_valid%0d", b), {31'd0, o_valid}, 32'd1);
      check($sformatf("b2b_data%0d", b), {16'd0, o_data},
            {16'd0, 16'((b < NN) ? (200 + b) : (300 + b - NN))});
      check($sformatf("b2b_last%0d", b), {31'd0, o_last}, {31'd0, (b == NN - 1) || (b == 2 * NN - 1)});
      if (b == 3) begin
        for (int i = 0; i < NN; i++) set_word(i, 16'(300 + i));
        i_valid = '1;
      end else begin
        i_valid = '0;
      end
      tick();
    end
    check("b2b_end_valid", {31'd0, o_valid}, 32'd0);
    check("b2b_ovf", {31'd0, overflow}, 32'd0);

    // Overflow: neuron 3 pulsed again before neuron 9; the second value is dropped.
    for (int j = 0; j < NN - 1; j++) begin
      i_valid = '0;
      i_valid[j] = 1'b1;
      set_word(j, 16'(400 + j));
      tick();
    end
    i_valid = '0;
    i_valid[3] = 1'b1;
    set_word(3, 16'd999);
    tick();
    check("ovf_set", {31'd0, overflow}, 32'd1);
    i_valid = '0;
    i_valid[NN-1] = 1'b1;
    set_word(NN - 1, 16'(400 + NN - 1));
    tick();
    i_valid = '0;
    tick();
    expect_stream("ovf", 400);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-stream at beat 5.
    for (int i = 0; i < NN; i++) set_word(i, 16'(500 + i));
    i_valid = '1;
    tick();
    i_valid = '0;
    tick();
    for (int k = 0; k < 5; k++) tick();
    check("mrst_beat5_data", {16'd0, o_data}, 32'd505);
    rstn = 1'b0;
    #1;
    check("mrst_valid", {31'd0, o_valid}, 32'd0);
    check("mrst_data", {16'd0, o_data}, 32'd0);
    check("mrst_last", {31'd0, o_last}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    check("mrst_hold_valid", {31'd0, o_valid}, 32'd0);
    rstn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("mrst_quiet%0d", k), {31'd0, o_valid}, 32'd0);
    end
    for (int i = 0; i < NN; i++) set_word(i, 16'(600 + i));
    i_valid = '1;
    tick();
    i_valid = '0;
    tick();
    expect_stream("post_rst", 600);

`ifdef LAYER_SER_ARGMAX_EN
    // Argmax: -3, 7, 7, -32768, 2, 0... -> index 1 (tie keeps the lower index).
    i_data = '0;
    set_word(0, 16'hFFFD);
    set_word(1, 16'd7);
    set_word(2, 16'd7);
    set_word(3, 16'h8000);
    set_word(4, 16'd2);
    i_valid = '1;
    tick();
    i_valid = '0;
    tick();
    for (int k = 0; k < NN; k++) begin
      check($sformatf("amax_quiet%0d", k), {31'd0, max_valid}, 32'd0);
      tick();
    end
    check("amax_pulse", {31'd0, max_valid}, 32'd1);
    check("amax_idx", {28'd0, max_idx}, 32'd1);
    tick();
    check("amax_pulse_end", {31'd0, max_valid}, 32'd0);
    check("amax_idx_hold", {28'd0, max_idx}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Converts the parallel output of a fully connected layer (one result per neuron, each with its own valid bit) into the one-word-per-cycle input stream the next layer's neurons consume. Sits between two layer instances in the network pipeline, and after the final layer when a classification index is needed. Per-neuron results are collected, handed to a stream buffer once complete, and emitted in neuron order. A new vector can be collected while the previous one is streaming out.

## Interface
- `NN`, 10, number of neurons in the upstream layer (words per vector); must be ≥ 2.
- `dataWidth`, 16, width of one signed fixed-point word.
- `clk`  in  1  single clock; all logic on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `i_valid`  in  NN  per-neuron result valid from the upstream layer; bit i qualifies slice i.
- `i_data`  in  NN*dataWidth  neuron i result at `[i*dataWidth +: dataWidth]`.
- `o_valid`  out  1  stream word valid; drives the next layer's input valid.
- `o_data`  out  dataWidth  stream word; drives the next layer's input.
- `o_last`  out  1  high with the word from neuron NN-1.
- `busy`  out  1  high when any collect bit is set or the stream is active.
- `overflow`  out  1  sticky error; a result arrived for a neuron already holding an untransferred result.
- `max_idx`  out  $clog2(NN)  argmax of the last streamed vector (only with `LAYER_SER_ARGMAX_EN`).
- `max_valid`  out  1  one-cycle pulse when `max_idx` updates (only with `LAYER_SER_ARGMAX_EN`).

## Operation
- Collect stage: registers `cap[NN]` and mask `mask[NN]`. When `i_valid[i]`=1 and `mask[i]`=0, store the slice in `cap[i]` and set `mask[i]`. Bits may arrive in any cycles, in any order.
- Transfer condition: `mask` is all ones, and the FSM is in IDLE or in STREAM with `cnt`==NN-1. On transfer: copy `cap` to `buf` and clear `mask`. FSM enters or stays in STREAM with `cnt`=0.
- An `i_valid[i]` in the transfer cycle sets `mask[i]` and writes `cap[i]` for the next vector. This is not an overflow.
- Overflow: `i_valid[i]`=1 while `mask[i]`=1 and no transfer occurs that cycle. The new word is dropped, `cap[i]` is kept, and `overflow` is set. `overflow` clears only on reset.
- FSM states:
  - IDLE: `o_valid`=0.
  - STREAM: `o_valid`=1, `o_data`=`buf[cnt]`, `o_last`=(`cnt`==NN-1). `cnt` increments each cycle.
  - At `cnt`==NN-1: go to STREAM (`cnt`=0) if the transfer condition holds, else go to IDLE.
- There is no backpressure; downstream neurons accept one word per cycle.
- Width rule: `cnt` is `$clog2(NN)` bits and never wraps past NN-1.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_last`=0, `busy`=0, `overflow`=0, `max_idx`=0, `max_valid`=0. `mask`=0, `cnt`=0, FSM=IDLE. Reset is legal mid-stream: the partial vector is discarded and the next cycle after release is IDLE.
- All outputs are registered.
- Latency: if all `i_valid` bits are high in cycle T, `mask` is full in T+1, the transfer happens at the end of T+1, and the first word appears in T+2. The last word appears in T+NN+1.
- Back-to-back: a vector completing while the previous one streams produces no idle gap. Its first word follows the previous `o_last` cycle directly.
- Minimum vector period without overflow: NN cycles.

## Configuration
- `LAYER_SER_ARGMAX_EN` defined: enables a running signed-max tracker over the streamed words.
  - Strict greater-than compare, so ties keep the lowest index.
  - `max_idx` and `max_valid` update in the cycle after the `o_last` word. `max_idx` holds until the next update.
- Undefined: the tracker and both ports are absent; all other behaviour is unchanged.

## Structure
- Package `layer_ser_pkg`:
  - FSM state typedef (`SER_IDLE`, `SER_STREAM`).
  - Function `idx_w(nn)` returning `$clog2(nn)`.
- Sub-module `seq_argmax`, instantiated only under `LAYER_SER_ARGMAX_EN`.
  - Inputs: valid, data, last, index.
  - Outputs: `max_idx`, `max_valid`.

## Test plan
- Basic vector: NN=10, all `i_valid` high in one cycle, neuron i value = i+1.
  - `o_data` = 1..10 in cycles T+2..T+11.
  - `o_last` high only in T+11.
  - `busy` falls after the stream.
- Staggered arrival: bits arrive one per cycle in order 9 down to 0.
  - No output until bit 0 arrives.
  - Stream starts 2 cycles after bit 0, in order 0..9.
- Back-to-back vectors: second vector completes during stream of the first.
  - 20 consecutive `o_valid` cycles, with `o_last` at beats 10 and 20.
  - `overflow`=0.
- Overflow: `i_valid[3]` pulsed twice before neuron 9 arrives.
  - `overflow`=1 and stays 1.
  - Streamed word 3 equals the first value.
- Reset mid-stream: assert `rstn`=0 at beat 5.
  - All outputs are 0 during reset.
  - No further `o_valid` until a new complete vector arrives.
- Argmax (macro on): words {-3, 7, 7, -32768, 2, …}.
  - `max_idx`=1.
  - `max_valid` pulses once, one cycle after `o_last`.
